// File: rtl/retire_store_buffer_if.sv
// rtl/retire_store_buffer_if.sv - Retire, D-cache drain and load-probe bundle for the committed-store buffer
// master = core/cache side, slave = the store buffer.
`ifndef XLEN
`define XLEN 32
`endif

interface retire_store_buffer_if #(
  parameter int SB_DEPTH = 4,
  parameter int XLEN     = `XLEN
);
  localparam int CNT_W = $clog2(SB_DEPTH) + 1;

  logic              store_en;
  logic [XLEN-1:0]   store_addr;
  logic [XLEN-1:0]   store_data;
  logic [1:0]        store_size;

  logic              sb_full;
  logic              sb_empty;
  logic [CNT_W-1:0]  sb_count;

  logic              sb2Dcache_req;
  logic [XLEN-1:0]   sb2Dcache_addr;
  logic [XLEN-1:0]   sb2Dcache_data;
  logic [1:0]        sb2Dcache_size;
  logic              Dcache2sb_ack;

  logic [XLEN-1:0]   ld_addr;
  logic [1:0]        ld_size;
  logic              ld_conflict;
  logic              ld_fwd_hit;
  logic [XLEN-1:0]   ld_fwd_data;

  logic              overflow_err;

  modport master (
    output store_en, store_addr, store_data, store_size,
    output Dcache2sb_ack, ld_addr, ld_size,
    input  sb_full, sb_empty, sb_count,
    input  sb2Dcache_req, sb2Dcache_addr, sb2Dcache_data, sb2Dcache_size,
    input  ld_conflict, ld_fwd_hit, ld_fwd_data, overflow_err
  );

  modport slave (
    input  store_en, store_addr, store_data, store_size,
    input  Dcache2sb_ack, ld_addr, ld_size,
    output sb_full, sb_empty, sb_count,
    output sb2Dcache_req, sb2Dcache_addr, sb2Dcache_data, sb2Dcache_size,
    output ld_conflict, ld_fwd_hit, ld_fwd_data, overflow_err
  );
endinterface

// File: rtl/retire_store_buffer.sv
// rtl/retire_store_buffer.sv - Committed-store FIFO draining to the D-cache with load overlap check
// Optional store-to-load forwarding is enabled by defining STORE_BUF_FWD_EN.
`ifndef XLEN
`define XLEN 32
`endif

module retire_store_buffer #(
  parameter int SB_DEPTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  retire_store_buffer_if.slave bus
);
  localparam int XLEN  = `XLEN;
  localparam int PTR_W = $clog2(SB_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(SB_DEPTH);

  typedef enum logic {S_IDLE, S_REQ} state_t;

  state_t            state_q;
  logic              req_q;
  logic [XLEN-1:0]   addr_q  [SB_DEPTH];
  logic [XLEN-1:0]   data_q  [SB_DEPTH];
  logic [1:0]        size_q  [SB_DEPTH];
  logic [SB_DEPTH-1:0] valid_q;
  logic [PTR_W-1:0]  head_q;
  logic [PTR_W-1:0]  tail_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;
  logic              overflow_q;

  logic full;
  logic empty;
  logic pop;
  logic push;
  logic drop;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);
  // A full buffer still takes a store when the head leaves in the same cycle.
  assign pop   = req_q & bus.Dcache2sb_ack;
  assign push  = bus.store_en & (~full | pop);
  assign drop  = bus.store_en & ~push;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      valid_q    <= '0;
      for (int i = 0; i < SB_DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        size_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      if (drop) begin
        overflow_q <= 1'b1;
      end
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + 1'b1;
      end
      // At full, tail == head: the push below re-validates the slot the pop just freed.
      if (push) begin
        valid_q[tail_q] <= 1'b1;
        addr_q[tail_q]  <= bus.store_addr;
        data_q[tail_q]  <= bus.store_data;
        size_q[tail_q]  <= bus.store_size;
        tail_q          <= tail_q + 1'b1;
      end
    end
  end

  // Looks at the post-update count so a push into an empty buffer requests next cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (count_d != '0) begin
            state_q <= S_REQ;
            req_q   <= 1'b1;
          end
        end
        S_REQ: begin
          if (count_d == '0) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sb_full        = full;
  assign bus.sb_empty       = empty;
  assign bus.sb_count       = count_q;
  assign bus.overflow_err   = overflow_q;
  assign bus.sb2Dcache_req  = req_q;
  assign bus.sb2Dcache_addr = req_q ? addr_q[head_q] : '0;
  assign bus.sb2Dcache_data = req_q ? data_q[head_q] : '0;
  assign bus.sb2Dcache_size = req_q ? size_q[head_q] : '0;

  logic [SB_DEPTH-1:0] word_match;
  logic                fwd_hit;
  logic [XLEN-1:0]     fwd_data;

  always_comb begin
    word_match = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      word_match[i] = valid_q[i] && (addr_q[i][XLEN-1:2] == bus.ld_addr[XLEN-1:2]);
    end
  end

`ifdef STORE_BUF_FWD_EN
  logic [PTR_W-1:0] age_idx;
  logic [PTR_W-1:0] young_idx;
  logic             young_found;

  // Walk oldest to youngest so the last match seen is the youngest store.
  always_comb begin
    age_idx     = '0;
    young_idx   = '0;
    young_found = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      age_idx = head_q + PTR_W'(i);
      if (word_match[age_idx]) begin
        young_found = 1'b1;
        young_idx   = age_idx;
      end
    end
  end

  assign fwd_hit  = young_found
                    && (addr_q[young_idx] == bus.ld_addr)
                    && (size_q[young_idx] == bus.ld_size);
  assign fwd_data = fwd_hit ? data_q[young_idx] : '0;
`else
  logic unused_ld_bits;
  assign unused_ld_bits = ^{bus.ld_size, bus.ld_addr[1:0]};
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

  assign bus.ld_fwd_hit  = fwd_hit;
  assign bus.ld_fwd_data = fwd_data;
  assign bus.ld_conflict = (|word_match) & ~fwd_hit;

endmodule

// File: tb/tb_retire_store_buffer.sv
// tb/tb_retire_store_buffer.sv - Scoreboard bench for retire_store_buffer
// Expected drain order and occupancy come from a queue model updated as stores are driven.
module tb_retire_store_buffer;
  localparam int DEPTH = 4;
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  sz;
  } st_t;

  logic clock = 1'b0;
  logic reset = 1'b0;

  retire_store_buffer_if #(.SB_DEPTH(DEPTH)) sb_if ();

  retire_store_buffer #(.SB_DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (sb_if.slave)
  );

  always #5 clock = ~clock;

  int   n_checks = 0;
  int   n_fail   = 0;
  st_t  sb_q[$];
  int   cnt_m    = 0;
  logic ovf_m    = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; model state is compared before the edge, then updated.
  task automatic sb_cycle(input logic en, input logic [31:0] a, input logic [31:0] d,
                          input logic [1:0] s, input logic ack);
    logic pop_m;
    logic push_m;
    st_t  e;
    @(negedge clock);
    sb_if.store_en      = en;
    sb_if.store_addr    = a;
    sb_if.store_data    = d;
    sb_if.store_size    = s;
    sb_if.Dcache2sb_ack = ack;
    #1;
    check_eq("req",   sb_if.sb2Dcache_req, cnt_m != 0);
    check_eq("count", sb_if.sb_count, cnt_m);
    check_eq("full",  sb_if.sb_full, cnt_m == DEPTH);
    check_eq("empty", sb_if.sb_empty, cnt_m == 0);
    check_eq("ovf",   sb_if.overflow_err, ovf_m);
    pop_m = ack && (cnt_m != 0);
    if (pop_m) begin
      e = sb_q.pop_front();
      check_eq("drain_addr", sb_if.sb2Dcache_addr, e.addr);
      check_eq("drain_data", sb_if.sb2Dcache_data, e.data);
      check_eq("drain_size", sb_if.sb2Dcache_size, e.sz);
    end
    push_m = en && ((cnt_m < DEPTH) || pop_m);
    if (push_m) sb_q.push_back('{addr: a, data: d, sz: s});
    if (en && !push_m) ovf_m = 1'b1;
    cnt_m = sb_q.size();
    @(posedge clock);
    #1;
    sb_if.store_en      = 1'b0;
    sb_if.Dcache2sb_ack = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH && cnt_m != 0; i++) sb_cycle(1'b0, 32'h0, 32'h0, SZ_BYTE, 1'b1);
    sb_cycle(1'b0, 32'h0, 32'h0, SZ_BYTE, 1'b0);
  endtask

  task automatic probe(input string tag, input logic [31:0] a, input logic [1:0] s,
                       input logic exp_conf, input logic exp_hit, input logic [31:0] exp_data);
    @(negedge clock);
    sb_if.ld_addr = a;
    sb_if.ld_size = s;
    #1;
    check_eq({tag, "_conflict"}, sb_if.ld_conflict, exp_conf);
    check_eq({tag, "_hit"},      sb_if.ld_fwd_hit, exp_hit);
    check_eq({tag, "_data"},     sb_if.ld_fwd_data, exp_data);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    sb_if.store_en      = 1'b0;
    sb_if.store_addr    = '0;
    sb_if.store_data    = '0;
    sb_if.store_size    = '0;
    sb_if.Dcache2sb_ack = 1'b0;
    sb_if.ld_addr       = 32'hFFFF_FF00;
    sb_if.ld_size       = SZ_WORD;

    repeat (2) @(negedge clock);
    #1;
    check_eq("rst_req",   sb_if.sb2Dcache_req, 1'b0);
    check_eq("rst_empty", sb_if.sb_empty, 1'b1);
    check_eq("rst_full",  sb_if.sb_full, 1'b0);
    check_eq("rst_count", sb_if.sb_count, 0);
    check_eq("rst_ovf",   sb_if.overflow_err, 1'b0);
    check_eq("rst_addr",  sb_if.sb2Dcache_addr, 32'h0);
    check_eq("rst_data",  sb_if.sb2Dcache_data, 32'h0);
    check_eq("rst_conf",  sb_if.ld_conflict, 1'b0);
    @(negedge clock);
    reset = 1'b1;

    sb_cycle(1'b1, 32'h100, 32'hDEAD_BEEF, SZ_WORD, 1'b0);
    sb_cycle(1'b0, 32'h0, 32'h0, SZ_BYTE, 1'b1);
    sb_cycle(1'b0, 32'h0, 32'h0, SZ_BYTE, 1'b0);

    for (int i = 0; i < DEPTH; i++) sb_cycle(1'b1, 32'h400 + 32'(4 * i), $urandom, SZ_WORD, 1'b0);
    sb_cycle(1'b1, 32'h480, 32'h0000_0BAD, SZ_WORD, 1'b0);
    sb_cycle(1'b1, 32'h484, 32'h0000_600D, SZ_HALF, 1'b1);
    sb_cycle(1'b0, 32'h0, 32'h0, SZ_BYTE, 1'b0);
    drain();

    for (int i = 0; i < 10; i++) sb_cycle(1'b1, 32'h800 + 32'(4 * i), $urandom, 2'(i % 3), 1'b1);
    drain();

    sb_cycle(1'b1, 32'h200, 32'h11, SZ_WORD, 1'b0);
    sb_cycle(1'b1, 32'h200, 32'h22, SZ_WORD, 1'b0);
`ifdef STORE_BUF_FWD_EN
    probe("ld_w200", 32'h200, SZ_WORD, 1'b0, 1'b1, 32'h22);
`else
    probe("ld_w200", 32'h200, SZ_WORD, 1'b1, 1'b0, 32'h0);
`endif
    probe("ld_b201", 32'h201, SZ_BYTE, 1'b1, 1'b0, 32'h0);
    probe("ld_h202", 32'h202, SZ_HALF, 1'b1, 1'b0, 32'h0);
    probe("ld_w300", 32'h300, SZ_WORD, 1'b0, 1'b0, 32'h0);
    sb_if.ld_addr = 32'hFFFF_FF00;
    drain();

    sb_cycle(1'b1, 32'h500, 32'h55, SZ_WORD, 1'b0);
    sb_cycle(1'b1, 32'h504, 32'h66, SZ_BYTE, 1'b0);
    @(negedge clock);
    #1;
    check_eq("pre_rst_req", sb_if.sb2Dcache_req, 1'b1);
    check_eq("pre_rst_ovf", sb_if.overflow_err, ovf_m);
    reset = 1'b0;
    #1;
    check_eq("mid_rst_req",   sb_if.sb2Dcache_req, 1'b0);
    check_eq("mid_rst_count", sb_if.sb_count, 0);
    check_eq("mid_rst_empty", sb_if.sb_empty, 1'b1);
    check_eq("mid_rst_ovf",   sb_if.overflow_err, 1'b0);
    sb_q.delete();
    cnt_m = 0;
    ovf_m = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    sb_cycle(1'b0, 32'h0, 32'h0, SZ_BYTE, 1'b0);
    sb_cycle(1'b1, 32'h600, 32'h77, SZ_WORD, 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/retire_store_buffer.md
# retire_store_buffer

Committed-store buffer between the retire stage and the D-cache. Retire raises `store_en` for the ROB-head store as it commits, and this block queues the address, data and size in a FIFO. It then drains entries to the D-cache one at a time with a req/ack handshake. It can also forward committed-but-undrained store data to younger loads. Entries are architecturally committed, so a branch-mispredict clear never discards them.

## Interface
- Parameters
- `SB_DEPTH`, default 4: FIFO entries; power of two, ≥2.
- `XLEN` is taken from the codebase global define (32).
- Ports
- `clock` input 1: single clock, all state on rising edge.
- `reset` input 1: asynchronous, active-low; clears all state immediately.
- `store_en` input 1: retire commits a store this cycle.
- `store_addr` input XLEN: byte address of the store (retire `result`).
- `store_data` input XLEN: store data (retire `opb_value`).
- `store_size` input MEM_SIZE: BYTE/HALF/WORD.
- `sb_full` output 1: count == SB_DEPTH; ROB must not retire a store while high.
- `sb_empty` output 1: count == 0; the halt path waits for this before stopping.
- `sb_count` output $clog2(SB_DEPTH)+1: occupancy.
- `sb2Dcache_req` output 1: drain request valid.
- `sb2Dcache_addr` output XLEN: head entry address.
- `sb2Dcache_data` output XLEN: head entry data.
- `sb2Dcache_size` output MEM_SIZE: head entry size.
- `Dcache2sb_ack` input 1: D-cache accepted the current request this cycle.
- `ld_addr` input XLEN: address probed by an executing load.
- `ld_size` input MEM_SIZE: size of the probing load.
- `ld_conflict` output 1: a valid entry overlaps the load's word and is not forwardable. The load must stall.
- `ld_fwd_hit` output 1: forwarding succeeded (see Configuration).
- `ld_fwd_data` output XLEN: forwarded data, unshifted.
- `overflow_err` output 1: sticky; set when a store was dropped.

## Operation
- Storage is a circular FIFO with head pointer, tail pointer, count and a valid bit per entry. Pointers wrap modulo SB_DEPTH.
- **Push.** When `store_en` is high and the buffer is not full, or is full with `Dcache2sb_ack` in the same cycle, write the entry at the tail and advance the tail.
- **Dropped push.** `store_en` while full with no ack drops the store and sets `overflow_err`, which stays set until reset.
- **Drain FSM states:**
  - IDLE: `sb2Dcache_req`=0. Go to REQ when count≠0.
  - REQ: `sb2Dcache_req`=1, and addr/data/size come from the head entry.
    - On `Dcache2sb_ack`: pop the head. Stay in REQ if count after the update is ≠0, otherwise go to IDLE.
- Request fields stay stable while `req`=1 with no ack.
- **Simultaneous push and pop:** count is unchanged and both pointers advance. This holds at full and at count 1.
- **Push into an empty buffer:** the new entry is the head on the next cycle.
- **Overlap check:** compare on word address `addr[XLEN-1:2]` across all valid entries. `ld_conflict` is the OR of matches, masked by `ld_fwd_hit`.
- No flush input exists. A mispredict does not touch the buffer.

## Timing
- Push at edge t makes the entry visible as `sb2Dcache_req` starting in cycle t+1. Minimum residency is 1 cycle.
- Back-to-back acks drain one entry per cycle.
- `sb_full`, `sb_empty` and `sb_count` are derived from registered state and do not see the current cycle's push.
- `ld_conflict`, `ld_fwd_hit` and `ld_fwd_data` are combinational from `ld_addr`/`ld_size` and registered entries. An entry pushed this cycle is not seen.
- Reset values: all valid bits 0; pointers, count, `overflow_err` and `req` at 0; FSM in IDLE; `sb_empty`=1; `sb_full`=0; data outputs 0.
- Reset asserted mid-REQ drops `req` asynchronously, and the in-flight store is lost.

## Configuration
- **`STORE_BUF_FWD_EN` defined:**
  - Find the youngest valid entry whose word address matches.
  - If its address and size exactly equal the load's, then `ld_fwd_hit`=1, `ld_fwd_data` = that entry's data, and `ld_conflict`=0.
  - Otherwise `ld_conflict`=1.
- **Undefined:** `ld_fwd_hit`=0 and `ld_fwd_data`=0 always. Any word match raises `ld_conflict`.

## Test plan
- **Reset:** release reset, push WORD 0x100/0xDEADBEEF → `req`=1 the next cycle with that addr/data. Ack → `sb_empty`=1 and `req`=0.
- **Fill and stall:** hold `ack` low and push 4 stores → `sb_full`=1, `sb_count`=4. A 5th push without ack → dropped and `overflow_err`=1. A 5th push with ack → accepted and count stays 4.
- **Order and wrap-around:** ack continuously while pushing 10 stores → requests come out in push order with no gaps.
- **Forwarding (FWD_EN):** push WORD 0x200/0x11 then WORD 0x200/0x22. Load WORD 0x200 → hit, data 0x22. Load BYTE 0x201 → `ld_conflict`=1 and hit=0.
- **Forwarding off (FWD_EN undefined):** same stimulus → hit=0 and `ld_conflict`=1. A load at 0x300 → `ld_conflict`=0.
- **Reset mid-drain:** assert reset while `req`=1 → `req`=0 immediately, count 0, `overflow_err` cleared.
